pc_fetch: RTL and testbench

- Instruction-fetch stage: owns the PC, drives a req/ack instruction bus, and presents the fetched word to the IF/ID pipeline register.
- Applies branch redirects from ID and exception redirects (flush/new_pc) from ctrl.
- Discards in-flight fetches that a redirect has made stale.
- Raises stallreq_if to ctrl while waiting on the bus, so ctrl stalls IF and IF/ID injects a bubble.

---
 rtl/pc_fetch_pkg.sv | 20 ++
 rtl/pc_fetch.sv | 171 +++++++++++++++++
 tb/tb_pc_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared constants and fetch-state encodings for the instruction-fetch stage.
package pc_fetch_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int InstAddrBusW = 32;
  localparam int InstBusW     = 32;

  localparam logic [InstBusW-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC ownership, req/ack bus handshake, redirect handling.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned fetch targets into if_adel instead of a bus request.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = InstAddrBusW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   new_pc,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  input  logic                ibus_ack_i,
  input  logic [InstBusW-1:0] ibus_rdata_i,
  output logic                ibus_req_o,
  output logic [ADDR_W-1:0]   ibus_addr_o,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [InstBusW-1:0] if_inst,
  output logic                stallreq_if,
  output logic                if_adel
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [InstBusW-1:0] inst_buf_q, inst_buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic                pend_branch_q, pend_branch_d;
  logic [ADDR_W-1:0]   pend_target_q, pend_target_d;
  logic                advance;
  logic                launch;
  logic [ADDR_W-1:0]   launch_addr;
  logic [ADDR_W-1:0]   next_pc;
  logic [4:0]          unused_stall;
`ifdef PC_ALIGN_CHECK_EN
  logic                adel_q, adel_d;
`endif

  assign unused_stall = stall[5:1];
  assign advance = (state_q == FETCH_HOLD) && (stall[0] == NoStop);

  always_comb begin
    next_pc = pc_q + ADDR_W'(4);
    if (branch_flag_i)      next_pc = branch_target_address_i;
    else if (pend_branch_q) next_pc = pend_target_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_d         = req_q;
    addr_d        = addr_q;
    inst_buf_d    = inst_buf_q;
    buf_valid_d   = buf_valid_q;
    pend_branch_d = pend_branch_q;
    pend_target_d = pend_target_q;
    launch        = 1'b0;
    launch_addr   = pc_q;
`ifdef PC_ALIGN_CHECK_EN
    adel_d        = adel_q;
`endif
    if (flush) begin
      pc_d          = new_pc;
      buf_valid_d   = 1'b0;
      pend_branch_d = 1'b0;
      launch_addr   = new_pc;
`ifdef PC_ALIGN_CHECK_EN
      adel_d        = 1'b0;
`endif
      // An un-acked request must still complete on the bus, so it is drained rather than dropped.
      case (state_q)
        FETCH_REQ:   if (ibus_ack_i) launch = 1'b1; else state_d = FETCH_DRAIN;
        FETCH_DRAIN: if (ibus_ack_i) launch = 1'b1;
        default:     launch = 1'b1;
      endcase
    end else begin
      case (state_q)
        FETCH_IDLE: launch = 1'b1;
        FETCH_REQ: begin
          if (ibus_ack_i) begin
            inst_buf_d  = ibus_rdata_i;
            buf_valid_d = 1'b1;
            req_d       = 1'b0;
            state_d     = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (advance) begin
            pc_d          = next_pc;
            buf_valid_d   = 1'b0;
            pend_branch_d = 1'b0;
            launch        = 1'b1;
            launch_addr   = next_pc;
`ifdef PC_ALIGN_CHECK_EN
            adel_d        = 1'b0;
`endif
          end
        end
        FETCH_DRAIN: if (ibus_ack_i) launch = 1'b1;
        default: state_d = FETCH_IDLE;
      endcase
      if (branch_flag_i && !advance) begin
        pend_branch_d = 1'b1;
        pend_target_d = branch_target_address_i;
      end
    end

    if (launch) begin
`ifdef PC_ALIGN_CHECK_EN
      if (launch_addr[1:0] != 2'b00) begin
        state_d     = FETCH_HOLD;
        req_d       = 1'b0;
        inst_buf_d  = ZeroWord;
        buf_valid_d = 1'b1;
        adel_d      = 1'b1;
      end else begin
        state_d = FETCH_REQ;
        req_d   = 1'b1;
        addr_d  = launch_addr;
      end
`else
      state_d = FETCH_REQ;
      req_d   = 1'b1;
      addr_d  = launch_addr;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      req_q         <= 1'b0;
      addr_q        <= ADDR_W'(RESET_PC);
      inst_buf_q    <= ZeroWord;
      buf_valid_q   <= 1'b0;
      pend_branch_q <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      inst_buf_q    <= inst_buf_d;
      buf_valid_q   <= buf_valid_d;
      pend_branch_q <= pend_branch_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) adel_q <= 1'b0;
    else                  adel_q <= adel_d;
  end
  assign if_adel = adel_q;
`else
  assign if_adel = 1'b0;
`endif

  assign ibus_req_o  = req_q;
  assign ibus_addr_o = addr_q;
  assign if_pc       = buf_valid_q ? pc_q : '0;
  assign if_inst     = buf_valid_q ? inst_buf_q : ZeroWord;
  assign stallreq_if = (state_q != FETCH_HOLD);

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed bus/redirect vectors, monitor checks acked addresses and presented words.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        if_adel;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_pres_q[$];
  logic        prev_stallreq = 1'b1;

  pc_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
    .ibus_ack_i(ibus_ack_i), .ibus_rdata_i(ibus_rdata_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle ack once a request is visible (bounded wait).
  task automatic ack(input logic [31:0] data);
    int n = 0;
    while (!ibus_req_o && n < 20) begin
      tick();
      n++;
    end
    if (!ibus_req_o) chk("ack_wait_req", 32'(ibus_req_o), 32'd1);
    ibus_ack_i   = 1'b1;
    ibus_rdata_i = data;
    tick();
    ibus_ack_i   = 1'b0;
    ibus_rdata_i = 32'h0;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] d, input bit presented);
    exp_addr_q.push_back(a);
    if (presented) exp_pres_q.push_back({a, d});
  endtask

  // Monitor: bus address on every accepted ack, and every newly presented instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (ibus_req_o && ibus_ack_i) begin
        if (exp_addr_q.size() == 0) chk("mon_unexpected_ack", ibus_addr_o, 32'hFFFF_FFFF);
        else chk("mon_ack_addr", ibus_addr_o, exp_addr_q.pop_front());
      end
      if (!stallreq_if && prev_stallreq) begin
        if (exp_pres_q.size() == 0) begin
          chk("mon_unexpected_pres", if_inst, 32'hFFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_pres_q.pop_front();
          chk("mon_if_pc", if_pc, e[63:32]);
          chk("mon_if_inst", if_inst, e[31:0]);
        end
      end
    end
    prev_stallreq <= rst ? 1'b1 : stallreq_if;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 6'b000001; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    ibus_ack_i = 1'b0; ibus_rdata_i = '0;
    tick(); tick();
    chk("rst_req", 32'(ibus_req_o), 32'd0);
    chk("rst_addr", ibus_addr_o, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_stallreq", 32'(stallreq_if), 32'd1);
    chk("rst_adel", 32'(if_adel), 32'd0);
    rst = 1'b0;

    // 1: first fetch, one wait cycle before ack
    tick();
    chk("t1_req", 32'(ibus_req_o), 32'd1);
    chk("t1_addr", ibus_addr_o, 32'h0);
    tick();
    chk("t1_stallreq_wait", 32'(stallreq_if), 32'd1);
    expect_fetch(32'h0, 32'h3C01_0001, 1);
    ack(32'h3C01_0001);
    chk("t1_stallreq_hold", 32'(stallreq_if), 32'd0);

    // 2: hold three cycles, then release
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_pc", if_pc, 32'h0);
      chk("t2_hold_inst", if_inst, 32'h3C01_0001);
      chk("t2_hold_req", 32'(ibus_req_o), 32'd0);
    end
    stall = 6'b000000;
    tick();
    stall = 6'b000001;
    chk("t2_rel_addr", ibus_addr_o, 32'h4);
    chk("t2_rel_req", 32'(ibus_req_o), 32'd1);
    chk("t2_rel_inst", if_inst, 32'h0);
    chk("t2_rel_pc", if_pc, 32'h0);
    expect_fetch(32'h4, 32'h2402_0005, 1);
    ack(32'h2402_0005);

    // 3: branch while stalled is remembered
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    tick();
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    tick();
    chk("t3_still_hold_pc", if_pc, 32'h4);
    stall = 6'b000000;
    tick();
    stall = 6'b000001;
    chk("t3_branch_addr", ibus_addr_o, 32'h100);
    expect_fetch(32'h100, 32'h8C22_0008, 1);
    ack(32'h8C22_0008);

    // 4: flush with a request outstanding drains the stale ack
    stall = 6'b000000;
    tick();
    stall = 6'b000001;
    chk("t4_seq_addr", ibus_addr_o, 32'h104);
    flush = 1'b1; new_pc = 32'h20;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("t4_drain_req", 32'(ibus_req_o), 32'd1);
    chk("t4_drain_addr", ibus_addr_o, 32'h104);
    chk("t4_drain_stallreq", 32'(stallreq_if), 32'd1);
    tick();
    expect_fetch(32'h104, 32'hDEAD_BEEF, 0);
    ack(32'hDEAD_BEEF);
    chk("t4_new_addr", ibus_addr_o, 32'h20);
    chk("t4_new_inst", if_inst, 32'h0);
    expect_fetch(32'h20, 32'h2063_0001, 1);
    ack(32'h2063_0001);

    // 5: flush beats a simultaneous branch and clears any pending branch
    flush = 1'b1; new_pc = 32'h40;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    chk("t5_flush_addr", ibus_addr_o, 32'h40);
    expect_fetch(32'h40, 32'h1111_0040, 1);
    ack(32'h1111_0040);
    stall = 6'b000000;
    tick();
    stall = 6'b000001;
    chk("t5_no_pend_addr", ibus_addr_o, 32'h44);
    expect_fetch(32'h44, 32'h1111_0044, 1);
    ack(32'h1111_0044);

    // pc+4 wraps at the top of the address space
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("wrap_top_addr", ibus_addr_o, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC, 32'h2222_0000, 1);
    ack(32'h2222_0000);
    stall = 6'b000000;
    tick();
    stall = 6'b000001;
    chk("wrap_addr", ibus_addr_o, 32'h0);
    expect_fetch(32'h0, 32'h3C01_0001, 1);
    ack(32'h3C01_0001);

`ifdef PC_ALIGN_CHECK_EN
    // 6: misaligned redirect raises if_adel without a bus request
    flush = 1'b1; new_pc = 32'h22;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("t6_req", 32'(ibus_req_o), 32'd0);
    chk("t6_adel", 32'(if_adel), 32'd1);
    chk("t6_if_pc", if_pc, 32'h22);
    chk("t6_if_inst", if_inst, 32'h0);
    chk("t6_stallreq", 32'(stallreq_if), 32'd0);
    flush = 1'b1; new_pc = 32'h80;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("t6_clear_adel", 32'(if_adel), 32'd0);
    chk("t6_clear_addr", ibus_addr_o, 32'h80);
    expect_fetch(32'h80, 32'h3333_0080, 1);
    ack(32'h3333_0080);
`else
    chk("adel_tied", 32'(if_adel), 32'd0);
`endif

    tick(); tick();
    chk("sb_addr_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("sb_pres_empty", 32'(exp_pres_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
